// File: rtl/qlab5_nios2_qsys_0_oci_dct_ctrl.sv
// DCT trace packer: shifts 2-bit codes into a 30-bit word and hands words to the trace store.
// Optional idle auto-flush of partial words when QLAB5_DCT_AUTOFLUSH_EN is defined.
module qlab5_nios2_qsys_0_oci_dct_ctrl #(
  parameter int SLOT_W = 2,
  parameter int SLOTS = 15,
  parameter int CNT_W = 4
`ifdef QLAB5_DCT_AUTOFLUSH_EN
  ,
  parameter int IDLE_TIMEOUT = 64
`endif
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     trc_on,
  input  logic                     dct_in_valid,
  input  logic [SLOT_W-1:0]        dct_in_code,
  output logic                     dct_in_ready,
  input  logic                     flush_req,
  output logic [SLOT_W*SLOTS-1:0]  dct_buffer,
  output logic [CNT_W-1:0]         dct_count,
  output logic                     out_valid,
  output logic [SLOT_W*SLOTS-1:0]  out_data,
  output logic [CNT_W-1:0]         out_count,
  input  logic                     out_ready,
  output logic                     overflow,
  output logic                     trace_ended
);

  localparam int BW = SLOT_W * SLOTS;

  typedef enum logic [1:0] {RUN, FLUSH, ENDED} state_t;

  state_t state, state_n;
  logic out_free, run, accept, full_held, ld;
  logic ovf_n, ended_n;
  logic [BW-1:0] shifted, buf_n, ld_data;
  logic [CNT_W-1:0] cnt_n, ld_cnt, cnt_inc;

  assign out_free = !out_valid || out_ready;
  assign run = state == RUN;
  assign full_held = dct_count == CNT_W'(SLOTS);
  assign dct_in_ready = reset_n && run && trc_on
                        && (dct_count < CNT_W'(SLOTS) || out_free);
  assign accept = dct_in_valid && dct_in_ready;
  assign shifted = {dct_buffer[BW-SLOT_W-1:0], dct_in_code};
  assign cnt_inc = dct_count + CNT_W'(1);

`ifdef QLAB5_DCT_AUTOFLUSH_EN
  localparam int IW = $clog2(IDLE_TIMEOUT + 1);
  logic [IW-1:0] idle;
  logic idle_hit;

  assign idle_hit = run && trc_on && !accept && dct_count != '0
                    && idle == IW'(IDLE_TIMEOUT - 1);
`endif

  always_comb begin
    ld = 1'b0;
    ld_data = dct_buffer;
    ld_cnt = dct_count;
    buf_n = dct_buffer;
    cnt_n = dct_count;
    state_n = state;
    ended_n = trace_ended;
    ovf_n = overflow || (dct_in_valid && !dct_in_ready && run);
    if (!trc_on) begin
      buf_n = '0;
      cnt_n = '0;
      state_n = RUN;
      ended_n = 1'b0;
      ovf_n = 1'b0;
    end else begin
      case (state)
        RUN: begin
          // a held full word leaves first; a same-cycle code starts the next word
          if (full_held && out_free) begin
            ld = 1'b1;
            ld_cnt = CNT_W'(SLOTS);
            buf_n = accept ? BW'(dct_in_code) : '0;
            cnt_n = accept ? CNT_W'(1) : '0;
          end else if (accept && cnt_inc == CNT_W'(SLOTS) && out_free) begin
            ld = 1'b1;
            ld_data = shifted;
            ld_cnt = cnt_inc;
            buf_n = '0;
            cnt_n = '0;
          end else if (accept) begin
            buf_n = shifted;
            cnt_n = cnt_inc;
          end
`ifdef QLAB5_DCT_AUTOFLUSH_EN
          else if (idle_hit && out_free) begin
            ld = 1'b1;
            buf_n = '0;
            cnt_n = '0;
          end
`endif
          if (flush_req) state_n = FLUSH;
        end
        FLUSH: begin
          if (dct_count != '0 && out_free) begin
            ld = 1'b1;
            buf_n = '0;
            cnt_n = '0;
          end else if (dct_count == '0 && !out_valid) begin
            state_n = ENDED;
            ended_n = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= RUN;
      dct_buffer <= '0;
      dct_count <= '0;
      out_valid <= 1'b0;
      out_data <= '0;
      out_count <= '0;
      overflow <= 1'b0;
      trace_ended <= 1'b0;
    end else begin
      state <= state_n;
      dct_buffer <= buf_n;
      dct_count <= cnt_n;
      overflow <= ovf_n;
      trace_ended <= ended_n;
      if (ld) begin
        out_valid <= 1'b1;
        out_data <= ld_data;
        out_count <= ld_cnt;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef QLAB5_DCT_AUTOFLUSH_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idle <= '0;
    end else if (!run || !trc_on || accept || ld || dct_count == '0) begin
      idle <= '0;
    end else if (idle != IW'(IDLE_TIMEOUT - 1)) begin
      idle <= idle + IW'(1);
    end
  end
`endif

endmodule
